ch_event_frontend: RTL and testbench
====================================

Name: ch_event_frontend

Overview:
- Input stage that sits directly upstream of the multi-channel counter/serializer core.
- Takes up to 8 raw asynchronous channel inputs and conditions each one: synchronizer, glitch filter, rising-edge detection.
- Keeps one pending flag per channel and arbitrates the pending events round-robin into a single valid/ready event stream, with channel index, for the counting core.
- Flags events lost because a channel was already pending.

Parameters:
- NCH, 8, number of channels (1..8).
- IDX_W, 3, width of the channel index; must satisfy 2^IDX_W >= NCH.
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (>=2).
- FILT_LEN, 2, consecutive equal synchronized samples required to accept a new level (1..8).

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_in  in  NCH  raw asynchronous channel inputs; bit i is channel i.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event; transfer happens when ev_valid && ev_ready.
- ev_ch  out  IDX_W  index of the granted channel; stable while ev_valid=1.
- pend  out  NCH  current pending flags (debug/status).
- ovf_ch  out  NCH  sticky per-channel lost-event flags.
- ovf_any  out  1  OR of ovf_ch.
- clr_ovf  in  1  one-cycle pulse clears all ovf_ch bits.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of clk.
- Reset state:
  - Sync chains 0; filter histories 0; filtered levels 0; arm bits 0.
  - pend=0, ev_valid=0, ev_ch=0, ovf_ch=0, ovf_any=0.
  - Round-robin pointer = 0.
- Reset mid-operation: takes priority over all other updates, including an in-flight ev_valid/ev_ready transfer. The event is dropped, and the consumer sees ev_valid=0 on the next cycle.
- Synchronizer: a plain SYNC_STAGES-deep flop chain per channel.
- Glitch filter:
  - A FILT_LEN-sample history of the synchronizer output.
  - The filtered level changes only when all FILT_LEN samples are equal and differ from the current filtered level.
  - A pulse shorter than FILT_LEN cycles after synchronization never changes the filtered level.
- Arming:
  - After reset, a channel's first filter acceptance loads its filtered level and sets its arm bit, without generating an event.
  - A channel held high through reset therefore produces no event.
- Edge detect: an armed channel whose filtered level goes 0->1 asserts set_i for one cycle.
- Pending, per channel:
  - set_i && !pend_i: pend_i <= 1.
  - set_i && pend_i, and not cleared this cycle: pend_i stays 1, and ovf_ch_i <= 1 (event lost).
  - Same-cycle grant-clear and set_i: set wins, pend_i stays 1, no overflow.
  - clr_ovf and a new overflow on the same channel in the same cycle: overflow wins, bit stays 1.
- Output register and arbiter:
  - When ev_valid=0 or a transfer occurs this cycle, the arbiter searches pend (excluding any bit being cleared this cycle) starting at pointer, wrapping modulo NCH.
  - On a hit: ev_valid<=1, ev_ch<=idx, pointer<=(idx+1) mod NCH.
  - With no hit: ev_valid<=0.
  - Back-to-back transfers are allowed, one per cycle.
- Grant-clear: the pend bit of ev_ch is cleared on the transfer cycle, not at grant. The channel stays pending while it is presented.
- Latency: a clean rising edge on an idle channel that is stable from cycle 0 gives ev_valid=1 at cycle SYNC_STAGES+FILT_LEN+2, which is 6 with the defaults. The bench checks this exact value.
- Back-pressure: with ev_ready=0 indefinitely, ev_valid and ev_ch hold. Further edges on the presented channel set ovf_ch for that channel.

Optional Feature:
- Macro: CH_BOTHEDGE_EN.
- Defined:
  - Falling filtered edges on armed channels also generate events.
  - Adds output port ev_edge (1 bit; 1=rising, 0=falling), registered with ev_ch.
  - Each channel has separate rise and fall pending bits. Within a channel, the rise bit is arbitrated before the fall bit.
  - Overflow rules apply to each pending bit independently.
- Not defined:
  - Rising edges only.
  - ev_edge port absent.

Test Plan:
1. Latency: reset 2 cycles, all ch_in=0 for 10 cycles, then ch_in[3] 0->1 held -> ev_valid rises exactly 6 cycles later with ev_ch=3; ev_ready=1 -> pend[3]=0 next cycle, no further events.
2. Glitch filter: 1-cycle high pulse on ch_in[5] -> no event, pend=0. Then a 3-cycle pulse -> exactly one event, ch 5.
3. Round-robin: simultaneous rising edges on ch 0, 2 and 7 with ev_ready=1 -> events in order 0, 2, 7 on consecutive cycles. Then ch 0 and 7 again with pointer=0 -> 0 then 7.
4. Back-pressure/overflow: ev_ready=0, two separate edges on ch 1 -> ev_valid=1, ev_ch=1 held, ovf_ch=8'h02, ovf_any=1. clr_ovf pulse -> ovf_ch=0. ev_ready=1 -> one event transferred.
5. Set vs clear: align a new ch 4 edge (set_4) with the transfer cycle of a pending ch 4 event -> pend[4] stays 1, ovf_ch[4]=0, second ch 4 event delivered.
6. Reset: ch_in[6] held high through reset -> no event after release. Assert reset while ev_valid=1 -> next cycle ev_valid=0, pend=0, ovf_ch=0.

Source files
------------

// File: rtl/ch_event_frontend.sv
// ch_event_frontend
//   Input conditioning and event arbitration in front of the multi-channel
//   counter/serializer core. Each raw channel goes through a synchronizer,
//   a glitch filter and a rising-edge detector. Detected edges set a pending
//   flag per channel. Pending flags are granted round-robin onto a single
//   valid/ready event stream that carries the channel index. An edge that
//   arrives while its channel is already pending is recorded in a sticky
//   overflow flag.
//   Build option: define CH_BOTHEDGE_EN to also report falling edges. This
//   adds the ev_edge output (1 = rising, 0 = falling).
module ch_event_frontend #(
    parameter int NCH         = 8,
    parameter int IDX_W       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   ch_in,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_ch,
`ifdef CH_BOTHEDGE_EN
    output logic             ev_edge,
`endif
    output logic [NCH-1:0]   pend,
    output logic [NCH-1:0]   ovf_ch,
    output logic             ovf_any,
    input  logic             clr_ovf
);

    // A filter decision is trusted only once the sync chain and the history
    // contain samples taken after reset, not the values that reset loaded.
    localparam int FILL_N = SYNC_STAGES + FILT_LEN;
    localparam int FILL_W = $clog2(FILL_N + 1);

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q, sync_d;
    logic [NCH-1:0][FILT_LEN-1:0]    hist_q, hist_d;
    logic [NCH-1:0]                  filt_q, filt_d;
    logic [NCH-1:0]                  arm_q, arm_d;
    logic [FILL_W-1:0]               fill_q, fill_d;

    logic [NCH-1:0] set_r, clr_r, avail_r, rise_q, rise_d;
`ifdef CH_BOTHEDGE_EN
    logic [NCH-1:0] set_f, clr_f, avail_f, fall_q, fall_d;
    logic           ev_edge_q, ev_edge_d;
`endif
    logic [NCH-1:0]   ovf_q, ovf_d;
    logic             ev_valid_q, ev_valid_d;
    logic [IDX_W-1:0] ev_ch_q, ev_ch_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             xfer;

    // Synchronize, filter and arm each channel, and detect filtered edges.
    always_comb begin
        // NOTE: every signal driven here gets a default before any branch, so no path can infer a latch.
        sync_d = sync_q;
        hist_d = hist_q;
        filt_d = filt_q;
        arm_d  = arm_q;
        set_r  = '0;
`ifdef CH_BOTHEDGE_EN
        set_f  = '0;
`endif
        sync_d[0] = ch_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        fill_d = (fill_q == FILL_W'(FILL_N)) ? fill_q : fill_q + FILL_W'(1);

        for (int i = 0; i < NCH; i++) begin
            hist_d[i][0] = sync_q[SYNC_STAGES-1][i];
            for (int k = 1; k < FILT_LEN; k++) begin
                hist_d[i][k] = hist_q[i][k-1];
            end
            if ((fill_q == FILL_W'(FILL_N)) && ((&hist_q[i]) || !(|hist_q[i]))) begin
                if (!arm_q[i]) begin
                    // The first stable level after reset only arms the channel.
                    arm_d[i]  = 1'b1;
                    filt_d[i] = hist_q[i][0];
                end else if (hist_q[i][0] != filt_q[i]) begin
                    filt_d[i] = hist_q[i][0];
                    set_r[i]  = hist_q[i][0];
`ifdef CH_BOTHEDGE_EN
                    set_f[i]  = !hist_q[i][0];
`endif
                end
            end
        end
    end

    // Pending flags and overflow: a new edge beats a grant-clear, and a new overflow beats clr_ovf.
    always_comb begin
        xfer  = ev_valid_q && ev_ready;
        clr_r = '0;
`ifdef CH_BOTHEDGE_EN
        clr_f = '0;
        if (xfer && ev_edge_q) clr_r[ev_ch_q] = 1'b1;
        if (xfer && !ev_edge_q) clr_f[ev_ch_q] = 1'b1;
        avail_f = fall_q & ~clr_f;
        fall_d  = set_f | avail_f;
`else
        if (xfer) clr_r[ev_ch_q] = 1'b1;
`endif
        avail_r = rise_q & ~clr_r;
        rise_d  = set_r | avail_r;
        ovf_d   = (set_r & avail_r) | (ovf_q & {NCH{!clr_ovf}});
`ifdef CH_BOTHEDGE_EN
        ovf_d   = ovf_d | (set_f & avail_f);
`endif
    end

    // Round-robin grant into the output register whenever it is empty or being drained.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_v;
        logic             found;
        ev_valid_d = ev_valid_q;
        ev_ch_d    = ev_ch_q;
        ptr_d      = ptr_q;
`ifdef CH_BOTHEDGE_EN
        ev_edge_d  = ev_edge_q;
`endif
        idx   = 0;
        idx_v = '0;
        found = 1'b0;
        if (!ev_valid_q || xfer) begin
            ev_valid_d = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NCH) idx = idx - NCH;
                idx_v = IDX_W'(idx);
`ifdef CH_BOTHEDGE_EN
                if (!found && (avail_r[idx_v] || avail_f[idx_v])) begin
                    ev_edge_d = avail_r[idx_v];
`else
                if (!found && avail_r[idx_v]) begin
`endif
                    found      = 1'b1;
                    ev_valid_d = 1'b1;
                    ev_ch_d    = idx_v;
                    ptr_d      = (idx == NCH - 1) ? '0 : IDX_W'(idx + 1);
                end
            end
        end
    end

    // State registers; reset takes priority, even over a transfer in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sync_q     <= '0;
            hist_q     <= '0;
            filt_q     <= '0;
            arm_q      <= '0;
            fill_q     <= '0;
            rise_q     <= '0;
            ovf_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_ch_q    <= '0;
            ptr_q      <= '0;
`ifdef CH_BOTHEDGE_EN
            fall_q     <= '0;
            ev_edge_q  <= 1'b0;
`endif
        end else begin
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            filt_q     <= filt_d;
            arm_q      <= arm_d;
            fill_q     <= fill_d;
            rise_q     <= rise_d;
            ovf_q      <= ovf_d;
            ev_valid_q <= ev_valid_d;
            ev_ch_q    <= ev_ch_d;
            ptr_q      <= ptr_d;
`ifdef CH_BOTHEDGE_EN
            fall_q     <= fall_d;
            ev_edge_q  <= ev_edge_d;
`endif
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_ch    = ev_ch_q;
`ifdef CH_BOTHEDGE_EN
    assign ev_edge  = ev_edge_q;
    assign pend     = rise_q | fall_q;
`else
    assign pend     = rise_q;
`endif
    assign ovf_ch   = ovf_q;
    assign ovf_any  = |ovf_q;

endmodule

// File: tb/tb_ch_event_frontend.sv
// Testbench for ch_event_frontend (default build, rising edges only).
// Directed vectors from a table, hand-written corner sequences, then random
// stimulus compared against a behavioural model.
module tb_ch_event_frontend;

    localparam int NCH   = 8;
    localparam int IDX_W = 3;
    localparam int SS    = 2;
    localparam int FL    = 2;

    logic             clk;
    logic             reset;
    logic [NCH-1:0]   ch_in;
    logic             ev_valid;
    logic             ev_ready;
    logic [IDX_W-1:0] ev_ch;
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   ovf_ch;
    logic             ovf_any;
    logic             clr_ovf;
`ifdef CH_BOTHEDGE_EN
    logic             ev_edge;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ch_event_frontend #(.NCH(NCH), .IDX_W(IDX_W), .SYNC_STAGES(SS), .FILT_LEN(FL)) dut (
        .clk      (clk),
        .reset    (reset),
        .ch_in    (ch_in),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_ch    (ev_ch),
`ifdef CH_BOTHEDGE_EN
        .ev_edge  (ev_edge),
`endif
        .pend     (pend),
        .ovf_ch   (ovf_ch),
        .ovf_any  (ovf_any),
        .clr_ovf  (clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       rst;
        logic [7:0] ch;
        logic       rdy;
        logic       clr;
        logic       chk;
        logic       v;
        logic [2:0] c;
        logic [7:0] p;
        logic [7:0] o;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Compare every output against one expected state.
    task automatic check_outputs(input string tag, input int v, input int c, input int p, input int o);
        check({tag, ".ev_valid"}, int'(ev_valid), v);
        if (v != 0) check({tag, ".ev_ch"}, int'(ev_ch), c);
        check({tag, ".pend"}, int'(pend), p);
        check({tag, ".ovf_ch"}, int'(ovf_ch), o);
        check({tag, ".ovf_any"}, int'(ovf_any), int'(o != 0));
    endtask

    // Drive one cycle of inputs, then sample just after the next rising edge.
    task automatic step(input int r, input int c, input int rdy, input int co);
        reset    = 1'(r);
        ch_in    = NCH'(c);
        ev_ready = 1'(rdy);
        clr_ovf  = 1'(co);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int rst, input int ch, input int rdy, input int clr,
                       input int chk, input int v, input int c, input int p, input int o);
        vec_t e;
        e.rst = 1'(rst); e.ch = 8'(ch); e.rdy = 1'(rdy); e.clr = 1'(clr);
        e.chk = 1'(chk); e.v = 1'(v); e.c = 3'(c); e.p = 8'(p); e.o = 8'(o);
        tbl.push_back(e);
    endtask

    task automatic reset_idle(input int ch, input int rdy);
        step(1, ch, rdy, 0);
        step(1, ch, rdy, 0);
        check_outputs("reset_state", 0, 0, 0, 0);
        repeat (10) step(0, ch, rdy, 0);
    endtask

    // ---------------- behavioural model ----------------
    logic [NCH-1:0] m_smp[$];
    logic [NCH-1:0] m_lvl, m_arm, m_pend, m_ovf;
    logic           m_valid;
    int             m_ch, m_ptr;

    task automatic model_reset();
        m_smp.delete();
        m_lvl = '0; m_arm = '0; m_pend = '0; m_ovf = '0;
        m_valid = 1'b0; m_ch = 0; m_ptr = 0;
    endtask

    // One clock edge: the filter window is the FL input samples taken SS+1..SS+FL edges ago.
    task automatic model_step(input logic [NCH-1:0] c, input logic rdy, input logic clr);
        int             n, ones, cc;
        logic [NCH-1:0] set, clrm, avail, s;
        logic           lvl, xf;
        n   = m_smp.size() + 1;
        set = '0;
        if (n > SS + FL) begin
            for (int i = 0; i < NCH; i++) begin
                ones = 0;
                for (int j = n - SS - FL; j <= n - 1 - SS; j++) begin
                    s = m_smp[j-1];
                    ones += int'(s[i]);
                end
                if (ones == FL || ones == 0) begin
                    lvl = (ones == FL);
                    if (!m_arm[i]) begin
                        m_arm[i] = 1'b1;
                        m_lvl[i] = lvl;
                    end else if (lvl != m_lvl[i]) begin
                        m_lvl[i] = lvl;
                        set[i]   = lvl;
                    end
                end
            end
        end
        m_smp.push_back(c);
        xf    = m_valid && rdy;
        clrm  = xf ? NCH'(1) << m_ch : '0;
        avail = m_pend & ~clrm;
        m_ovf = (clr ? '0 : m_ovf) | (set & avail);
        m_pend = set | avail;
        if (!m_valid || xf) begin
            m_valid = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                cc = (m_ptr + k) % NCH;
                if (!m_valid && avail[cc]) begin
                    m_valid = 1'b1;
                    m_ch    = cc;
                    m_ptr   = (cc + 1) % NCH;
                end
            end
        end
    endtask

    int             ev_cnt;
    int             last_ch;
    int             hold[NCH];
    logic [NCH-1:0] rnd_ch;
    logic           rnd_rdy, rnd_clr;

    initial begin
        reset = 1'b1; ch_in = '0; ev_ready = 1'b0; clr_ovf = 1'b0;

        // ---- table: round-robin order, then back-pressure and overflow ----
        add(1, 8'h00, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        add(1, 8'h00, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 8'h85, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        add(0, 8'h85, 1, 0, 1, 0, 0, 8'h85, 8'h00);
        add(0, 8'h85, 1, 0, 1, 1, 0, 8'h85, 8'h00);
        add(0, 8'h85, 1, 0, 1, 1, 2, 8'h84, 8'h00);
        add(0, 8'h85, 1, 0, 1, 1, 7, 8'h80, 8'h00);
        add(0, 8'h85, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) add(0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) add(0, 8'h81, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        add(0, 8'h81, 1, 0, 1, 0, 0, 8'h81, 8'h00);
        add(0, 8'h81, 1, 0, 1, 1, 0, 8'h81, 8'h00);
        add(0, 8'h81, 1, 0, 1, 1, 7, 8'h80, 8'h00);
        add(0, 8'h81, 1, 0, 1, 0, 0, 8'h00, 8'h00);

        add(1, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00);
        add(1, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 8'h02, 0, 0, 1, 0, 0, 8'h00, 8'h00);
        add(0, 8'h00, 0, 0, 1, 0, 0, 8'h02, 8'h00);
        for (int i = 0; i < 4; i++) add(0, 8'h00, 0, 0, 1, 1, 1, 8'h02, 8'h00);
        for (int i = 0; i < 4; i++) add(0, 8'h02, 0, 0, 1, 1, 1, 8'h02, 8'h00);
        add(0, 8'h02, 0, 0, 1, 1, 1, 8'h02, 8'h02);
        add(0, 8'h02, 0, 0, 1, 1, 1, 8'h02, 8'h02);
        add(0, 8'h02, 0, 0, 1, 1, 1, 8'h02, 8'h02);
        add(0, 8'h02, 0, 1, 1, 1, 1, 8'h02, 8'h00);
        add(0, 8'h02, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        add(0, 8'h02, 1, 0, 1, 0, 0, 8'h00, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            step(int'(tbl[i].rst), int'(tbl[i].ch), int'(tbl[i].rdy), int'(tbl[i].clr));
            if (tbl[i].chk)
                check_outputs($sformatf("vec%0d", i), int'(tbl[i].v), int'(tbl[i].c),
                              int'(tbl[i].p), int'(tbl[i].o));
        end

        // ---- latency: ev_valid exactly 6 cycles after a clean edge on ch 3 ----
        reset_idle(8'h00, 1);
        for (int k = 1; k <= 6; k++) begin
            step(0, 8'h08, 1, 0);
            check_outputs($sformatf("latency_k%0d", k), int'(k == 6), 3, (k >= 5) ? 8'h08 : 8'h00, 0);
        end
        step(0, 8'h08, 1, 0);
        check_outputs("latency_drained", 0, 0, 8'h00, 0);
        ev_cnt = 0;
        repeat (8) begin
            step(0, 8'h08, 1, 0);
            if (ev_valid) ev_cnt++;
        end
        check("latency_no_more_events", ev_cnt, 0);

        // ---- glitch filter on ch 5 ----
        reset_idle(8'h00, 1);
        step(0, 8'h20, 1, 0);
        ev_cnt = 0;
        repeat (10) begin
            step(0, 8'h00, 1, 0);
            if (ev_valid) ev_cnt++;
        end
        check("glitch_1cyc_events", ev_cnt, 0);
        check("glitch_1cyc_pend", int'(pend), 0);
        ev_cnt = 0; last_ch = -1;
        for (int k = 0; k < 15; k++) begin
            step(0, (k < 3) ? 8'h20 : 8'h00, 1, 0);
            if (ev_valid) begin
                ev_cnt++;
                last_ch = int'(ev_ch);
            end
        end
        check("glitch_3cyc_events", ev_cnt, 1);
        check("glitch_3cyc_ch", last_ch, 5);

        // ---- set vs grant-clear on ch 4 ----
        reset_idle(8'h00, 0);
        for (int k = 0; k < 10; k++) step(0, (k < 3 || k >= 6) ? 8'h10 : 8'h00, 0, 0);
        check_outputs("setclr_presented", 1, 4, 8'h10, 0);
        step(0, 8'h10, 1, 0);
        check_outputs("setclr_same_cycle", 0, 0, 8'h10, 0);
        step(0, 8'h10, 1, 0);
        check_outputs("setclr_second_event", 1, 4, 8'h10, 0);
        step(0, 8'h10, 1, 0);
        check_outputs("setclr_drained", 0, 0, 8'h00, 0);

        // ---- reset: channel high through reset, then reset mid-operation ----
        step(0, 8'h40, 0, 0);
        reset_idle(8'h40, 1);
        ev_cnt = 0;
        repeat (4) begin
            step(0, 8'h40, 1, 0);
            if (ev_valid) ev_cnt++;
        end
        check("held_high_events", ev_cnt, 0);
        check("held_high_pend", int'(pend), 0);
        for (int k = 0; k < 12; k++) step(0, (k < 3 || k >= 6) ? 8'h48 : 8'h40, 0, 0);
        check_outputs("pre_reset", 1, 3, 8'h08, 8'h08);
        step(1, 8'h48, 1, 0);
        check_outputs("mid_reset", 0, 0, 8'h00, 8'h00);

        // ---- random stimulus against the model ----
        rnd_ch = '0;
        for (int i = 0; i < NCH; i++) hold[i] = $urandom_range(1, 7);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NCH; i++) begin
                if (hold[i] == 0) begin
                    rnd_ch[i] = ~rnd_ch[i];
                    hold[i]   = $urandom_range(1, 7);
                end
                hold[i]--;
            end
            rnd_rdy = ($urandom_range(0, 9) < 7);
            rnd_clr = ($urandom_range(0, 19) == 0);
            step(0, int'(rnd_ch), int'(rnd_rdy), int'(rnd_clr));
            model_step(rnd_ch, rnd_rdy, rnd_clr);
            check_outputs($sformatf("rnd%0d", cyc), int'(m_valid), m_ch, int'(m_pend), int'(m_ovf));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
